// File: rtl/opsel_pkg.sv
// Shared types and constants for the operand selector pipeline.
package opsel_pkg;

  localparam int NSRC_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Packed width of a {data, err} beat for a given operand width.
  function automatic int beat_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/opsel_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid come straight from flops.
module opsel_skid
  import opsel_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_beat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_beat
);

  state_t        state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_d   = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = in_beat;
        end else if (in_xfer) begin
          skid_d  = in_beat;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      // NOTE: both data registers are reset so out_data reads zero, never X, straight after reset.
      out_q       <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_beat  = out_q;

endmodule

// File: rtl/operand_sel_pipe.sv
// N:1 operand selector registered behind a skid buffer, with invalid-select reporting.
// Define OPSEL_ERR_CNT_EN to build the saturating err_count; otherwise err_count is tied to zero.
module operand_sel_pipe
  import opsel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int SELW  = $clog2(NSRC),
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err,
  output logic                  sel_err,
  output logic [CNTW-1:0]       err_count
);

  localparam int BEAT_W = beat_w(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             in_xfer;
  beat_t            in_beat, out_beat;
  logic             sel_err_q, sel_err_d;

  // Codes at or above NSRC match no source, leaving data zero and the error flag set.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) begin
        sel_data = src_data[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign in_beat = '{data: sel_data, err: sel_bad};
  assign in_xfer = in_valid & in_ready;

  opsel_skid #(
    .DW(BEAT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_beat  (in_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_beat (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_err  = out_beat.err;

  always_comb begin
    sel_err_d = sel_err_q | (in_xfer & sel_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

`ifdef OPSEL_ERR_CNT_EN
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_xfer && sel_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed self-checking bench for operand_sel_pipe (WIDTH=8, NSRC=3, CNTW=4).
module tb_operand_sel_pipe;

  localparam int WIDTH = 8;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;
  localparam int CNTW  = 4;

`ifdef OPSEL_ERR_CNT_EN
  localparam logic [CNTW-1:0] EXP_CNT1  = 4'd1;
  localparam logic [CNTW-1:0] EXP_CNTSAT = 4'd15;
`else
  localparam logic [CNTW-1:0] EXP_CNT1  = 4'd0;
  localparam logic [CNTW-1:0] EXP_CNTSAT = 4'd0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_err;
  logic                  sel_err;
  logic [CNTW-1:0]       err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_sel_pipe #(
    .WIDTH(WIDTH),
    .NSRC (NSRC),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src_data (src_data),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .sel_err  (sel_err),
    .err_count(err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    sel       = '0;
    out_ready = 1'b1;
    src_data  = {8'h33, 8'h22, 8'h11};

    // Reset held two cycles with in_valid high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_err_count", 32'(err_count), 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Streaming back-to-back, one cycle latency.
    in_valid = 1'b1;
    sel      = 2'd0;
    tick();
    check("stream0_valid", 32'(out_valid), 32'd1);
    check("stream0_data", 32'(out_data), 32'h11);
    sel = 2'd1;
    tick();
    check("stream1_data", 32'(out_data), 32'h22);
    sel = 2'd2;
    tick();
    check("stream2_data", 32'(out_data), 32'h33);
    check("stream2_err", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: three beats offered, two accepted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd2;
    tick();
    check("bp_one_ready", 32'(in_ready), 32'd1);
    check("bp_one_data", 32'(out_data), 32'h33);
    sel = 2'd1;
    tick();
    check("bp_two_ready", 32'(in_ready), 32'd0);
    check("bp_two_data", 32'(out_data), 32'h33);
    sel = 2'd0;
    tick();
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data), 32'h33);
    out_ready = 1'b1;
    tick();
    check("bp_drain1_data", 32'(out_data), 32'h22);
    check("bp_drain1_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_third_data", 32'(out_data), 32'h11);
    in_valid = 1'b0;
    tick();
    check("bp_empty_valid", 32'(out_valid), 32'd0);

    // Invalid select yields zero data and error reporting.
    in_valid = 1'b1;
    sel      = 2'd3;
    tick();
    check("inv_valid", 32'(out_valid), 32'd1);
    check("inv_data", 32'(out_data), 32'd0);
    check("inv_out_err", 32'(out_err), 32'd1);
    check("inv_sel_err", 32'(sel_err), 32'd1);
    check("inv_err_count", 32'(err_count), 32'(EXP_CNT1));
    sel = 2'd1;
    tick();
    check("inv_next_data", 32'(out_data), 32'h22);
    check("inv_next_out_err", 32'(out_err), 32'd0);
    check("inv_next_sel_err", 32'(sel_err), 32'd1);
    in_valid = 1'b0;
    tick();

    // Saturation: 20 more invalid beats on top of the earlier one.
    in_valid = 1'b1;
    sel      = 2'd3;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick();
    check("sat_err_count", 32'(err_count), 32'(EXP_CNTSAT));
    check("sat_sel_err", 32'(sel_err), 32'd1);

    // Reset while two beats are buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    check("pre_rst_two_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    check("rst2_sel_err", 32'(sel_err), 32'd0);
    check("rst2_err_count", 32'(err_count), 32'd0);
    check("rst2_out_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("rst2_no_ghost", 32'(out_valid), 32'd0);

    // Invalid select while full is ignored; order preserved on drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    sel = 2'd3;
    tick();
    check("full_inv_sel_err", 32'(sel_err), 32'd0);
    check("full_inv_err_count", 32'(err_count), 32'd0);
    check("full_inv_data", 32'(out_data), 32'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("full_drain_data", 32'(out_data), 32'h22);
    check("full_drain_err", 32'(out_err), 32'd0);
    tick();
    check("full_drain_empty", 32'(out_valid), 32'd0);
    check("full_final_sel_err", 32'(sel_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
